pipe_add: RTL and testbench
===========================

PIPE_ADD -- requirements
Module: pipe_add

Interface
REQ-001 Parameter WIDTH, default 64, total operand width; SHALL be a multiple of SEG.
REQ-002 Parameter SEG, default 16, segment width per pipeline stage; N = WIDTH/SEG stages, 1 <= N <= 8.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  pipeline accepts a beat this cycle.
REQ-007 a, b  input  WIDTH  unsigned/two's-complement operands.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 sub  input  1  subtract select (present only with PIPE_ADD_SUB_EN).
REQ-010 out_valid  output  1  result beat presented.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow flag.

Function
REQ-015 Stage k (0..N-1) SHALL add segment k of a and b with the carry registered from stage k-1 (stage 0 uses cin), segment internally carry-lookahead.
REQ-016 Operand segments k>0 SHALL be skewed by k register delays; result segments SHALL be de-skewed so all WIDTH bits of one beat appear together.
REQ-017 Latency SHALL be exactly N cycles from accepted beat (in_valid & in_ready) to out_valid for that beat, when no stall.
REQ-018 Throughput SHALL be one beat per cycle with out_ready held high.
REQ-019 advance = !out_valid | out_ready; in_ready SHALL equal advance; all stage registers and valid bits SHALL shift only when advance=1 (global stall).
REQ-020 While out_valid=1 and out_ready=0, sum, cout, ovf SHALL hold stable.
REQ-021 Per-stage valid bits SHALL track bubbles; in_valid=0 on an advancing cycle inserts a bubble, never a spurious result.
REQ-022 sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
REQ-023 ovf = carry into bit WIDTH-1 XOR cout.
REQ-024 Beats SHALL emerge in acceptance order; none dropped or duplicated outside reset.
REQ-025 in_ready may be 1 while in_valid=0; the handshake SHALL NOT depend on in_valid combinationally.

Reset
REQ-026 reset=1 SHALL clear all valid bits next edge: out_valid=0, in_ready=1 thereafter.
REQ-027 sum, cout, ovf SHALL reset to 0.
REQ-028 Reset mid-operation SHALL discard every in-flight beat; beats offered during the reset cycle are not accepted.

Configuration
REQ-029 Macro PIPE_ADD_SUB_EN defined: sub port exists; sub=1 computes a + ~b + 1 (cin ignored), cout=1 means no borrow, ovf per REQ-023; sub is pipelined with its beat.
REQ-030 PIPE_ADD_SUB_EN undefined: no sub port, no inversion logic; add only.

Structure
REQ-031 Shared package pipe_add_pkg SHALL hold N derivation (WIDTH/SEG), MAX_STAGES=8 and the add/sub op encoding.
REQ-032 One sub-module pipe_add_seg: SEG-bit lookahead segment adder (a, b, cin, sub -> sum, cout, carry into MSB), purely combinational; pipe_add instantiates N of them with registers between.

Verification (WIDTH=64, SEG=16, N=4)
REQ-033 a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> after 4 cycles sum=0, cout=1, ovf=0 (carry across all segments).
REQ-034 a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-035 4 back-to-back beats a=i, b=i*3 (i=1..4), out_ready=1 -> results 4,8,12,16 on 4 consecutive cycles starting cycle 4.
REQ-036 Stream with out_ready=0 for 3 cycles mid-stream -> in_ready=0 while output held, sum stable, no beat lost, order preserved.
REQ-037 reset pulse 2 cycles after accepting 2 beats -> out_valid stays 0, outputs 0, next accepted beat returns after 4 cycles.
REQ-038 With PIPE_ADD_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// pipe_add shared definitions: stage count, limits, op encoding.
// Optional subtract support is controlled by macro PIPE_ADD_SUB_EN.
package pipe_add_pkg;

  localparam int MAX_STAGES = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int num_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipe_add_seg.sv
// pipe_add_seg: one SEG-bit combinational lookahead segment adder.
// With PIPE_ADD_SUB_EN a sub input inverts b inside the segment.
module pipe_add_seg
  import pipe_add_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
`ifdef PIPE_ADD_SUB_EN
  input  logic           sub,
`endif
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG-1:0] bx;
  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  // generate/propagate terms and carry lookahead across the segment
  always_comb begin
`ifdef PIPE_ADD_SUB_EN
    bx = (sub == OP_SUB) ? ~b : b;
`else
    bx = b;
`endif
    g    = a & bx;
    p    = a ^ bx;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[SEG-1:0];
    cout = c[SEG];
    cmsb = c[SEG-1];
  end

endmodule

// File: rtl/pipe_add.sv
// pipe_add: WIDTH-bit adder split into WIDTH/SEG carry-pipelined stages.
// Macro PIPE_ADD_SUB_EN adds a sub port (a + ~b + 1, cin ignored).
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N = num_stages(WIDTH, SEG);

  logic         adv;
  logic         c0;
  logic [N-1:0] vin;
  logic [N-1:0] v_q, v_d;
  logic [N-1:0] c_q, c_d;
  logic [N-1:0] seg_co;
  logic [N-1:0] seg_cm;
  logic         cm_q, cm_d;
  logic         unused_ok;

  // global stall: everything shifts only when the output can move
  assign adv       = !v_q[N-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[N-1];
  assign cout      = c_q[N-1];
  assign ovf       = cm_q ^ c_q[N-1];

  // valid presented to each stage's input
  always_comb begin
    vin    = '0;
    vin[0] = in_valid;
    for (int k = 1; k < N; k++) begin
      vin[k] = v_q[k-1];
    end
  end

`ifdef PIPE_ADD_SUB_EN
  logic [N-1:0] op_in;
  logic [N-1:0] op_q, op_d;

  // op travels down the pipe alongside its beat
  always_comb begin
    op_in    = '0;
    op_in[0] = sub;
    for (int k = 1; k < N; k++) begin
      op_in[k] = op_q[k-1];
    end
    op_d = adv ? op_in : op_q;
  end

  // op register chain
  always_ff @(posedge clk) begin
    if (reset) op_q <= '0;
    else       op_q <= op_d;
  end

  assign c0        = (op_in[0] == OP_SUB) ? 1'b1 : cin;
  assign unused_ok = ^{seg_cm, op_q[N-1]};
`else
  assign c0        = cin;
  assign unused_ok = ^seg_cm;
`endif

  // valid bits, inter-stage carries and final MSB carry
  always_comb begin
    v_d  = v_q;
    c_d  = c_q;
    cm_d = cm_q;
    if (adv) begin
      v_d = vin;
      for (int k = 0; k < N; k++) begin
        if (vin[k]) c_d[k] = seg_co[k];
      end
      if (vin[N-1]) cm_d = seg_cm[N-1];
    end
  end

  // control/carry registers
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q  <= '0;
      c_q  <= '0;
      cm_q <= 1'b0;
    end else begin
      v_q  <= v_d;
      c_q  <= c_d;
      cm_q <= cm_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [SEG-1:0] sa;
    logic [SEG-1:0] sb;
    logic [SEG-1:0] ss;
    logic           ci;
    logic [SEG-1:0] rd_q [N-k];
    logic [SEG-1:0] rd_d [N-k];

    if (k == 0) begin : g_head
      assign sa = a[SEG-1:0];
      assign sb = b[SEG-1:0];
      assign ci = c0;
    end else begin : g_skew
      logic [SEG-1:0] ad_q [k];
      logic [SEG-1:0] ad_d [k];
      logic [SEG-1:0] bd_q [k];
      logic [SEG-1:0] bd_d [k];

      // operand skew: segment k waits k cycles for its carry
      always_comb begin
        ad_d = ad_q;
        bd_d = bd_q;
        if (adv) begin
          ad_d[0] = a[k*SEG +: SEG];
          bd_d[0] = b[k*SEG +: SEG];
          for (int j = 1; j < k; j++) begin
            ad_d[j] = ad_q[j-1];
            bd_d[j] = bd_q[j-1];
          end
        end
      end

      // operand skew registers
      always_ff @(posedge clk) begin
        if (reset) begin
          ad_q <= '{default: '0};
          bd_q <= '{default: '0};
        end else begin
          ad_q <= ad_d;
          bd_q <= bd_d;
        end
      end

      assign sa = ad_q[k-1];
      assign sb = bd_q[k-1];
      assign ci = c_q[k-1];
    end

    pipe_add_seg #(
      .SEG (SEG)
    ) u_seg (
      .a    (sa),
      .b    (sb),
      .cin  (ci),
`ifdef PIPE_ADD_SUB_EN
      .sub  (op_in[k]),
`endif
      .sum  (ss),
      .cout (seg_co[k]),
      .cmsb (seg_cm[k])
    );

    // result de-skew: hold segment k until the last stage is done
    always_comb begin
      rd_d = rd_q;
      if (adv && vin[k]) rd_d[0] = ss;
      for (int j = 1; j < N - k; j++) begin
        if (adv && vin[k+j]) rd_d[j] = rd_q[j-1];
      end
    end

    // result de-skew registers
    always_ff @(posedge clk) begin
      if (reset) rd_q <= '{default: '0};
      else       rd_q <= rd_d;
    end

    assign sum[k*SEG +: SEG] = rd_q[N-1-k];
  end

endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: directed checks of pipe_add (WIDTH=64, SEG=16).
// Sub vectors run only when PIPE_ADD_SUB_EN is defined.
module tb_pipe_add;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int n_chk;
  int n_pass;

  pipe_add #(
    .WIDTH (64),
    .SEG   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [63:0] va,
                         input logic [63:0] vb, input logic vc,
                         input logic vs, input logic [63:0] es,
                         input logic ec, input logic eo);
    int lat;
    a = va; b = vb; cin = vc; sub = vs;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, ".rdy"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'd4);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, 64'(cout), 64'(ec));
    check({tag, ".ovf"}, 64'(ovf), 64'(eo));
    step();
  endtask

  initial begin
    int sent;
    int got;
    int stalls;
    int seen;
    n_chk = 0; n_pass = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst.ovalid", 64'(out_valid), 64'd0);
    check("rst.irdy", 64'(in_ready), 64'd1);
    check("rst.sum", sum, 64'd0);
    check("rst.cout", 64'(cout), 64'd0);
    check("rst.ovf", 64'(ovf), 64'd0);

    run_one("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
            64'd0, 1'b1, 1'b0);
    run_one("maxpos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_one("minneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
    run_one("cin32", 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
            64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_one("segbd", 64'h0000_FFFF_0000_FFFF, 64'd1, 1'b1, 1'b0,
            64'h0000_FFFF_0001_0001, 1'b0, 1'b0);

    // four back-to-back beats, results on cycles 4..7
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      a = 64'(c + 1);
      b = 64'((c + 1) * 3);
      cin = 1'b0;
      step();
      if (c >= 3 && c <= 6) begin
        check($sformatf("b2b.v%0d", c), 64'(out_valid), 64'd1);
        check($sformatf("b2b.s%0d", c), sum, 64'(4 * (c - 2)));
      end else if (c == 7) begin
        check("b2b.end", 64'(out_valid), 64'd0);
      end
    end

    // stream of six beats with a three-cycle consumer stall
    sent = 0; got = 0; stalls = 0;
    for (int cy = 0; cy < 40 && got < 6; cy++) begin
      out_ready = !(cy >= 6 && cy <= 8);
      in_valid  = (sent < 6);
      a   = 64'(sent + 1);
      b   = 64'h0000_0000_0000_FFFF;
      cin = 1'b0;
      #1;
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("stl.s%0d", got), sum, 64'h1_0000 + 64'(got));
          got++;
        end else begin
          stalls++;
          check($sformatf("stl.ir%0d", cy), 64'(in_ready), 64'd0);
          check($sformatf("stl.h%0d", cy), sum, 64'h1_0000 + 64'(got));
        end
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stl.got", 64'(got), 64'd6);
    check("stl.stalls", 64'(stalls), 64'd3);
    step(); step(); step(); step();

    // reset while two beats are in flight
    in_valid = 1'b1; a = 64'd1; b = 64'd1; cin = 1'b0;
    step();
    a = 64'd2; b = 64'd2;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1; in_valid = 1'b1; a = 64'd9; b = 64'd9;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check("mrst.ovalid", 64'(out_valid), 64'd0);
    check("mrst.irdy", 64'(in_ready), 64'd1);
    check("mrst.sum", sum, 64'd0);
    check("mrst.cout", 64'(cout), 64'd0);
    check("mrst.ovf", 64'(ovf), 64'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("mrst.flush", 64'(seen), 64'd0);
    run_one("mrst.next", 64'h10, 64'h20, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0);

`ifdef PIPE_ADD_SUB_EN
    run_one("sub57", 64'd5, 64'd7, 1'b1, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_one("sub75", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
